// File: rtl/tm_pkg.sv
// Shared types and widths for the Turing-machine front panel.
package tm_pkg;
    localparam int SYM_W = 4;
    localparam int CNT_W = 7;

    typedef enum logic {
        MODE_ENTRY = 1'b0,
        MODE_RUN   = 1'b1
    } mode_e;
endpackage

// File: rtl/tm_input_conditioner_if.sv
// Panel-side bundle: raw switches/buttons in, conditioned strobes and status out.
interface tm_input_conditioner_if;
    import tm_pkg::*;

    logic             next_btn;
    logic             done_btn;
    logic [SYM_W-1:0] data_sw;
    logic             Next;
    logic             Done;
    logic [SYM_W-1:0] input_data;
    logic [CNT_W-1:0] symbol_count;
    logic             entry_full;
    logic             run_mode;

    modport slave (
        input  next_btn, done_btn, data_sw,
        output Next, Done, input_data, symbol_count, entry_full, run_mode
    );

    modport master (
        output next_btn, done_btn, data_sw,
        input  Next, Done, input_data, symbol_count, entry_full, run_mode
    );
endinterface

// File: rtl/tm_debounce.sv
// Button synchronizer + debounce filter; o_rise is high in the cycle before the filtered level goes 0->1.
// Filter (DEBOUNCE_CYCLES stable cycles) exists only with TM_DEBOUNCE_EN; otherwise the level tracks the synchronizer.
module tm_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);
    logic r_sync1;
    logic r_sync2;
    logic r_level;
    logic w_flip;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef TM_DEBOUNCE_EN
    logic [7:0] r_cnt;

    // Flip on the DEBOUNCE_CYCLES-th consecutive edge that still sees a differing level.
    assign w_flip = (r_sync2 != r_level) && (r_cnt == 8'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= 8'd0;
        end else if (w_flip) begin
            r_cnt   <= 8'd0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end
`else
    logic w_unused_cfg;

    // Debounce length is irrelevant when the filter is compiled out.
    assign w_unused_cfg = (DEBOUNCE_CYCLES != 0);
    assign w_flip       = (r_sync2 != r_level);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
        end else begin
            r_level <= r_sync2;
        end
    end
`endif

    assign o_rise = w_flip & r_sync2;
endmodule

// File: rtl/tm_input_conditioner.sv
// Front-panel conditioner: debounced Next/Done strobes, symbol capture and ENTRY/RUN mode (TM_DEBOUNCE_EN enables filtering).
// Pulse lands one cycle after edge N+2+DEBOUNCE_CYCLES (N+3 unfiltered); no backpressure, presses beyond TAPE_LEN are dropped.
module tm_input_conditioner
    import tm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TAPE_LEN        = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    tm_input_conditioner_if.slave  bus
);
    logic [SYM_W-1:0] r_sw_s1;
    logic [SYM_W-1:0] r_sw_s2;
    logic [SYM_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic             r_next_pend;
    logic             r_cnt_pend;
    logic             r_done_pend;
    logic             r_next;
    logic             r_done;
    logic             w_next_rise;
    logic             w_done_rise;
    logic             w_next_pend;
    logic             w_cnt_pend;
    logic             w_done_pend;
    logic             w_capture;
    logic             w_full;

    tm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clock  (clock),
        .reset  (reset),
        .i_btn  (bus.next_btn),
        .o_rise (w_next_rise)
    );

    tm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done_db (
        .clock  (clock),
        .reset  (reset),
        .i_btn  (bus.done_btn),
        .o_rise (w_done_rise)
    );

    assign w_full = (r_count == CNT_W'(TAPE_LEN));

    always_comb begin
        w_mode_nxt  = r_mode;
        w_next_pend = 1'b0;
        w_cnt_pend  = 1'b0;
        w_done_pend = 1'b0;
        w_capture   = 1'b0;
        case (r_mode)
            MODE_ENTRY: begin
                // Done takes priority; a coincident Next press is discarded.
                if (w_done_rise) begin
                    w_done_pend = 1'b1;
                    w_mode_nxt  = MODE_RUN;
                end else if (w_next_rise && !w_full) begin
                    w_capture   = 1'b1;
                    w_next_pend = 1'b1;
                    w_cnt_pend  = 1'b1;
                end
            end
            MODE_RUN: begin
                w_next_pend = w_next_rise;
            end
            default: w_mode_nxt = MODE_ENTRY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode <= MODE_ENTRY;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_data      <= '0;
            r_count     <= '0;
            r_next_pend <= 1'b0;
            r_cnt_pend  <= 1'b0;
            r_done_pend <= 1'b0;
            r_next      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sw_s1     <= bus.data_sw;
            r_sw_s2     <= r_sw_s1;
            r_next_pend <= w_next_pend;
            r_cnt_pend  <= w_cnt_pend;
            r_done_pend <= w_done_pend;
            r_next      <= r_next_pend;
            r_done      <= r_done_pend;
            if (w_capture) begin
                r_data <= r_sw_s2;
            end
            // Count advances on the same edge that raises Next, so data leads the pulse by one cycle.
            if (r_cnt_pend) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.Next         = r_next;
    assign bus.Done         = r_done;
    assign bus.input_data   = r_data;
    assign bus.symbol_count = r_count;
    assign bus.entry_full   = w_full;
    assign bus.run_mode     = (r_mode == MODE_RUN);
endmodule

// File: doc/tm_input_conditioner.md
TM_INPUT_CONDITIONER -- requirements
Module: tm_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles (range 2..255) before a button level is accepted.
REQ-002 SHALL have parameter TAPE_LEN, default 64, meaning the maximum number of symbols accepted in entry mode.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = asserted).
REQ-005 SHALL have port next_btn, input, 1 bit: raw, asynchronous, bouncing "Next" pushbutton.
REQ-006 SHALL have port done_btn, input, 1 bit: raw, asynchronous, bouncing "Done" pushbutton.
REQ-007 SHALL have port data_sw, input, 4 bits: raw symbol switches.
REQ-008 SHALL have port Next, output, 1 bit: single-cycle step/enter pulse to the Turing machine.
REQ-009 SHALL have port Done, output, 1 bit: single-cycle end-of-entry pulse.
REQ-010 SHALL have port input_data, output, 4 bits: latched symbol, stable around each Next pulse.
REQ-011 SHALL have port symbol_count, output, 7 bits: number of symbols accepted.
REQ-012 SHALL have port entry_full, output, 1 bit: high when symbol_count == TAPE_LEN.
REQ-013 SHALL have port run_mode, output, 1 bit: 0 = ENTRY, 1 = RUN.

Function
REQ-014 SHALL pass next_btn, done_btn and data_sw each through a 2-flop synchronizer.
REQ-015 SHALL flip a button's debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion in that window restarts the count.
REQ-016 SHALL produce an internal "rise" event on the cycle the debounced level goes 0->1; falling edges produce no event; holding the button produces exactly one event.
REQ-017 SHALL let a button held stable high from clock edge N produce its output pulse in the cycle after edge N+2+DEBOUNCE_CYCLES.
REQ-018 SHALL run a two-state FSM, ENTRY and RUN, where reset enters ENTRY.
REQ-019 In ENTRY with a Next rise and entry_full=0, SHALL capture the synchronized data_sw into input_data on that edge, then pulse Next for one cycle, and increment symbol_count on the same edge as the pulse.
REQ-020 In ENTRY with entry_full=1, SHALL drop Next rises: no pulse, no capture, count saturates at TAPE_LEN.
REQ-021 In ENTRY with a Done rise, SHALL pulse Done for one cycle and move to RUN.
REQ-022 When Next and Done rises coincide in ENTRY, Done SHALL win and the Next rise SHALL be dropped.
REQ-023 In RUN, SHALL forward each Next rise as a one-cycle Next pulse with input_data and symbol_count held unchanged.
REQ-024 In RUN, SHALL ignore Done rises; RUN is left only by reset.
REQ-025 SHALL never assert Next and Done in the same cycle, and SHALL always separate two Next pulses by at least one low cycle.

Reset
REQ-026 While reset=0, SHALL force Next=0, Done=0, input_data=0, symbol_count=0, entry_full=0, run_mode=0, and clear synchronizers, debounced levels and counters to 0.
REQ-027 Reset asserted mid-debounce or mid-pulse SHALL abort it; after release a button already held high SHALL produce one pulse per REQ-017 timing, counted from the first edge after release.

Configuration
REQ-028 With TM_DEBOUNCE_EN defined, SHALL debounce per REQ-015.
REQ-029 Without TM_DEBOUNCE_EN, SHALL omit the debounce counters so a rise follows the synchronizer directly, with a pulse in the cycle after edge N+3; all other behaviour is unchanged and DEBOUNCE_CYCLES is ignored.

Structure
REQ-030 SHALL take the mode enum (ENTRY/RUN), the symbol width (4) and the count width (7) from shared package tm_pkg.
REQ-031 SHALL implement synchronizer, debounce and rise detection in sub-module tm_debounce, instantiated once per button.

Verification
REQ-032 Bench SHALL cover: next_btn held high 6 cycles with data_sw=3 -> exactly one Next pulse at the REQ-017 cycle, input_data=3 one cycle before it, symbol_count=1.
REQ-033 Bench SHALL cover: next_btn bouncing 1,0,1,0 for single cycles, then stable high -> one pulse, timed from the last 0->1.
REQ-034 Bench SHALL cover: 65 clean Next presses with TAPE_LEN=64 -> 64 pulses, entry_full=1, 65th press gives no pulse.
REQ-035 Bench SHALL cover: next_btn and done_btn rising on the same edge in ENTRY -> Done pulse only, run_mode=1, symbol_count unchanged.
REQ-036 Bench SHALL cover: in RUN, 3 Next presses with data_sw changing -> 3 Next pulses, input_data frozen; done_btn press produces no Done pulse.
REQ-037 Bench SHALL cover: reset=0 asserted two cycles into a debounce window -> all outputs 0; after release with the button still held, one pulse at N+2+DEBOUNCE_CYCLES.
